// File: rtl/store_m.sv
// store_m: streams matrix tiles from a compute array out to byte-addressed memory, one element per cycle.
// Latency: write k of an accepted tile reaches the memory port k+1 cycles after the accepting edge; done follows the last row.
// Backpressure: tile_ready is high only in WAIT_TILE. The block stalls indefinitely while tile_valid is low. The memory port is never stalled.
//
// Ports:
//   clk, rst            clock (rising edge), asynchronous active-high reset
//   valid_in            start pulse; samples dram_addr / rows / cols in IDLE
//   dram_addr[23:0]     base byte address of the matrix
//   rows[9:0], cols[9:0] matrix rows and valid columns per row
//   tile_in/tile_valid  tile data (element e at [e*DATA_WIDTH +: DATA_WIDTH]) and its valid
//   tile_ready          high exactly while waiting for a tile
//   mem_we/mem_addr/mem_din  registered memory write port
//   busy, done          not-idle flag and one-cycle completion pulse
// Build option: STORE_M_SKIP_PAD_EN suppresses mem_we on padding columns. The address still advances on those columns.

package accelerator_config_pkg;
    localparam int TILE_WIDTH = 256;
    localparam int DATA_WIDTH = 8;
endpackage

module store_m #(
    parameter int TILE_WIDTH = accelerator_config_pkg::TILE_WIDTH,
    parameter int DATA_WIDTH = accelerator_config_pkg::DATA_WIDTH
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  valid_in,
    input  logic [23:0]           dram_addr,
    input  logic [9:0]            rows,
    input  logic [9:0]            cols,
    input  logic [TILE_WIDTH-1:0] tile_in,
    input  logic                  tile_valid,
    output logic                  tile_ready,
    output logic                  mem_we,
    output logic [23:0]           mem_addr,
    output logic [DATA_WIDTH-1:0] mem_din,
    output logic                  busy,
    output logic                  done
);

    localparam int TILE_ELEMS = TILE_WIDTH / DATA_WIDTH;
    localparam int EW         = (TILE_ELEMS > 1) ? $clog2(TILE_ELEMS) : 1;
    // The column counter runs up to tiles_per_row*TILE_ELEMS, which can exceed 1023.
    localparam int CW         = $clog2(1024 + TILE_ELEMS);

    typedef enum logic [2:0] {
        IDLE,
        WAIT_TILE,
        WRITING,
        NEXT_TILE,
        NEXT_ROW,
        DONE
    } state_t;

    state_t state_q, state_d;

    logic [23:0]   addr_q, addr_d;              // running write address
    logic [9:0]    rows_q, rows_d;
    logic [9:0]    cols_q, cols_d;
    logic [CW-1:0] tpr_q, tpr_d;                // tiles per row
    logic [9:0]    current_row_q, current_row_d;
    logic [CW-1:0] col_in_row_q, col_in_row_d;
    logic [CW-1:0] tile_in_row_q, tile_in_row_d;
    logic [EW-1:0] elem_cnt_q, elem_cnt_d;
    logic [TILE_ELEMS-1:0][DATA_WIDTH-1:0] tile_buf_q, tile_buf_d;

    logic                  mem_we_q, mem_we_d;
    logic [23:0]           mem_addr_q, mem_addr_d;
    logic [DATA_WIDTH-1:0] mem_din_q, mem_din_d;
    logic                  done_q, done_d;

    logic pad;

    // State register and all datapath flops
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= IDLE;
            addr_q        <= '0;
            rows_q        <= '0;
            cols_q        <= '0;
            tpr_q         <= '0;
            current_row_q <= '0;
            col_in_row_q  <= '0;
            tile_in_row_q <= '0;
            elem_cnt_q    <= '0;
            tile_buf_q    <= '0;
            mem_we_q      <= 1'b0;
            mem_addr_q    <= '0;
            mem_din_q     <= '0;
            done_q        <= 1'b0;
        end else begin
            state_q       <= state_d;
            addr_q        <= addr_d;
            rows_q        <= rows_d;
            cols_q        <= cols_d;
            tpr_q         <= tpr_d;
            current_row_q <= current_row_d;
            col_in_row_q  <= col_in_row_d;
            tile_in_row_q <= tile_in_row_d;
            elem_cnt_q    <= elem_cnt_d;
            tile_buf_q    <= tile_buf_d;
            mem_we_q      <= mem_we_d;
            mem_addr_q    <= mem_addr_d;
            mem_din_q     <= mem_din_d;
            done_q        <= done_d;
        end
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    state_d = (rows == 10'd0 || cols == 10'd0) ? DONE : WAIT_TILE;
                end
            end
            WAIT_TILE: begin
                if (tile_valid) begin
                    state_d = WRITING;
                end
            end
            WRITING: begin
                if (elem_cnt_q == EW'(TILE_ELEMS - 1)) begin
                    state_d = NEXT_TILE;
                end
            end
            NEXT_TILE: begin
                state_d = (tile_in_row_q + CW'(1) >= tpr_q) ? NEXT_ROW : WAIT_TILE;
            end
            NEXT_ROW: begin
                state_d = (current_row_q + 10'd1 >= rows_q) ? DONE : WAIT_TILE;
            end
            DONE: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Columns beyond the valid width of the row are padding.
    assign pad = (col_in_row_q >= CW'(cols_q));

    // Datapath and registered-output logic
    always_comb begin
        addr_d        = addr_q;
        rows_d        = rows_q;
        cols_d        = cols_q;
        tpr_d         = tpr_q;
        current_row_d = current_row_q;
        col_in_row_d  = col_in_row_q;
        tile_in_row_d = tile_in_row_q;
        elem_cnt_d    = elem_cnt_q;
        tile_buf_d    = tile_buf_q;
        mem_we_d      = 1'b0;
        mem_addr_d    = mem_addr_q;
        mem_din_d     = mem_din_q;
        done_d        = 1'b0;
        case (state_q)
            IDLE: begin
                if (valid_in) begin
                    addr_d        = dram_addr;
                    rows_d        = rows;
                    cols_d        = cols;
                    tpr_d         = (CW'(cols) + CW'(TILE_ELEMS - 1)) / CW'(TILE_ELEMS);
                    current_row_d = '0;
                    col_in_row_d  = '0;
                    tile_in_row_d = '0;
                    elem_cnt_d    = '0;
                end
            end
            WAIT_TILE: begin
                if (tile_valid) begin
                    tile_buf_d = tile_in;
                    elem_cnt_d = '0;
                end
            end
            WRITING: begin
`ifdef STORE_M_SKIP_PAD_EN
                mem_we_d   = !pad;
`else
                mem_we_d   = 1'b1;
`endif
                mem_addr_d = addr_q;
                mem_din_d  = pad ? '0 : tile_buf_q[elem_cnt_q];
                // Address advances on padding too, so every row has the same stride.
                addr_d       = addr_q + 24'd1;
                col_in_row_d = col_in_row_q + CW'(1);
                elem_cnt_d   = elem_cnt_q + EW'(1);
            end
            NEXT_TILE: begin
                tile_in_row_d = tile_in_row_q + CW'(1);
            end
            NEXT_ROW: begin
                current_row_d = current_row_q + 10'd1;
                col_in_row_d  = '0;
                tile_in_row_d = '0;
            end
            DONE: begin
                done_d = 1'b1;
            end
            default: begin
                done_d = 1'b0;
            end
        endcase
    end

    // Output logic
    assign tile_ready = (state_q == WAIT_TILE);
    assign busy       = (state_q != IDLE);
    assign mem_we     = mem_we_q;
    assign mem_addr   = mem_addr_q;
    assign mem_din    = mem_din_q;
    assign done       = done_q;

endmodule

// File: doc/store_m.md
STORE_M -- requirements
Module: store_m

Interface
REQ-001 SHALL have parameter TILE_WIDTH, default accelerator_config_pkg::TILE_WIDTH, tile width in bits.
REQ-002 SHALL have parameter DATA_WIDTH, default accelerator_config_pkg::DATA_WIDTH, element width in bits; TILE_ELEMS = TILE_WIDTH/DATA_WIDTH.
REQ-003 SHALL have port clk  input  1  clock, rising edge.
REQ-004 SHALL have port rst  input  1  reset, asynchronous, active-high.
REQ-005 SHALL have port valid_in  input  1  start pulse; samples dram_addr, rows and cols.
REQ-006 SHALL have port dram_addr  input  24  base byte address of the matrix.
REQ-007 SHALL have port rows  input  10  number of matrix rows.
REQ-008 SHALL have port cols  input  10  valid columns per row.
REQ-009 SHALL have port tile_in  input  TILE_WIDTH  tile data; element e at bits [e*DATA_WIDTH +: DATA_WIDTH].
REQ-010 SHALL have port tile_valid  input  1  tile_in is valid.
REQ-011 SHALL have port tile_ready  output  1  block accepts a tile this cycle.
REQ-012 SHALL have port mem_we  output  1  memory byte write enable.
REQ-013 SHALL have port mem_addr  output  24  memory write address.
REQ-014 SHALL have port mem_din  output  DATA_WIDTH  memory write data.
REQ-015 SHALL have port busy  output  1  high in every state except IDLE.
REQ-016 SHALL have port done  output  1  one-cycle completion pulse.

Function
REQ-017 SHALL implement the states IDLE, WAIT_TILE, WRITING, NEXT_TILE, NEXT_ROW and DONE.
REQ-018 In IDLE, valid_in SHALL latch the inputs and set tiles_per_row = ceil(cols/TILE_ELEMS). It SHALL go to DONE if rows==0 or cols==0, otherwise to WAIT_TILE.
REQ-019 tile_ready SHALL be high exactly while in WAIT_TILE.
REQ-020 A tile is accepted when tile_valid and tile_ready are both high. On acceptance the block SHALL register tile_in into an internal buffer and enter WRITING with elem_cnt=0.
REQ-021 In WRITING, the block SHALL issue one write per cycle for elem_cnt = 0..TILE_ELEMS-1. Each write is registered, so write k appears on the memory port k+1 cycles after the accepting edge.
REQ-022 Each write SHALL drive mem_addr = the running address (starting at dram_addr, incremented after every element) and mem_din = buffer element elem_cnt. If col_in_row >= cols, mem_din SHALL be 0 (padding).
REQ-023 The running address SHALL advance on every element, including padding, so each row occupies tiles_per_row*TILE_ELEMS bytes. It SHALL wrap modulo 2^24.
REQ-024 After the last element, the block SHALL pass one cycle in NEXT_TILE. It SHALL then go to NEXT_ROW if tile_in_row+1 >= tiles_per_row, otherwise back to WAIT_TILE.
REQ-025 NEXT_ROW SHALL increment current_row and clear col_in_row and tile_in_row. It SHALL go to DONE if current_row+1 >= rows, otherwise to WAIT_TILE.
REQ-026 DONE SHALL assert done for exactly one cycle and return to IDLE.
REQ-027 mem_we SHALL be high only for the writes issued by REQ-021 and REQ-022.
REQ-028 valid_in SHALL be ignored outside IDLE. tile_valid SHALL be ignored outside WAIT_TILE.
REQ-029 tile_valid held low in WAIT_TILE SHALL stall the block indefinitely, with no writes and no state change.

Reset
REQ-030 While rst is asserted, all outputs SHALL be 0, state SHALL be IDLE, and all counters and the buffer SHALL be cleared.
REQ-031 Reset asserted mid-operation SHALL abort the transfer immediately: no further mem_we and no done pulse.

Configuration
REQ-032 With macro STORE_M_SKIP_PAD_EN defined, padding elements (col_in_row >= cols) SHALL keep mem_we low while the address still advances.
REQ-033 With STORE_M_SKIP_PAD_EN undefined, padding elements SHALL be written as 0 with mem_we high.

Verification (TILE_WIDTH=256, DATA_WIDTH=8, TILE_ELEMS=32)
REQ-034 rows=2, cols=40, dram_addr=0x000100, four tiles with byte value = column index -> 128 writes at 0x100..0x17F; bytes at columns 40..63 of each row are 0; one done pulse.
REQ-035 rows=1, cols=32, dram_addr=0xFFFFF0 -> 32 writes at addresses 0xFFFFF0..0xFFFFFF, then 0x000000..0x00000F; a single tile_ready window.
REQ-036 rows=0 or cols=0 -> done 2 cycles after valid_in; tile_ready and mem_we never asserted.
REQ-037 tile_valid held low for 10 cycles in WAIT_TILE -> no mem_we and tile_ready stays high; transfer resumes on tile_valid.
REQ-038 rst pulsed during the 5th write of the 2nd tile -> all outputs 0, no further writes, no done; a new valid_in afterwards completes normally.
REQ-039 Build with STORE_M_SKIP_PAD_EN, rows=1, cols=5 -> exactly 5 writes with mem_we high; final running address is dram_addr+32.
